// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - MIPS memory-access / writeback-prep stage after the execute ALU
//
// definitions_pkg: opcode and funct constants shared by the pipeline.
//
// mem_stage ports:
//   clk, rst                      clock, asynchronous active-high reset
//   in_valid_i / in_ready_o       executed-instruction handshake
//   instr_i, alu_result_i,
//   store_data_i                  instruction word, ALU result / effective address, rt for SW
//   dmem_req_o / dmem_ack_i       data-memory request, held until acknowledged
//   dmem_we_o, dmem_addr_o,
//   dmem_wdata_o, dmem_rdata_i    request direction, byte address, store data, load data
//   wb_valid_o                    one-cycle pulse per retired instruction
//   wb_we_o, wb_rd_o, wb_data_o   register-file write record
//   err_o                         00 ok, 01 misaligned, 10 memory timeout

package definitions_pkg;
    localparam logic [5:0] OPCODE_RTYPE_SPECIAL1 = 6'h00;
    localparam logic [5:0] OPCODE_RTYPE_SPECIAL2 = 6'h1C;
    localparam logic [5:0] OPCODE_MUL            = 6'h1E;
    localparam logic [5:0] OPCODE_J              = 6'h02;
    localparam logic [5:0] OPCODE_BEQ            = 6'h04;
    localparam logic [5:0] OPCODE_BNE            = 6'h05;
    localparam logic [5:0] OPCODE_ADDI           = 6'h08;
    localparam logic [5:0] OPCODE_SLTI           = 6'h0A;
    localparam logic [5:0] OPCODE_ANDI           = 6'h0C;
    localparam logic [5:0] OPCODE_ORI            = 6'h0D;
    localparam logic [5:0] OPCODE_LW             = 6'h23;
    localparam logic [5:0] OPCODE_SW             = 6'h2B;
    localparam logic [5:0] FUNCT_ADD             = 6'h20;
endpackage

module mem_stage
    import definitions_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [31:0]       instr_i,
    input  logic [31:0]       alu_result_i,
    input  logic [31:0]       store_data_i,
    output logic              dmem_req_o,
    output logic              dmem_we_o,
    output logic [ADDR_W-1:0] dmem_addr_o,
    output logic [31:0]       dmem_wdata_o,
    input  logic              dmem_ack_i,
    input  logic [31:0]       dmem_rdata_i,
    output logic              wb_valid_o,
    output logic              wb_we_o,
    output logic [4:0]        wb_rd_o,
    output logic [31:0]       wb_data_o,
    output logic [1:0]        err_o
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MEM  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [1:0] ERR_OK        = 2'b00;
    localparam logic [1:0] ERR_MISALIGN  = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT   = 2'b10;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

    logic [1:0]        state_q,      state_d;
    logic              dmem_req_q,   dmem_req_d;
    logic              dmem_we_q,    dmem_we_d;
    logic [ADDR_W-1:0] dmem_addr_q,  dmem_addr_d;
    logic [31:0]       dmem_wdata_q, dmem_wdata_d;
    logic              wb_valid_q,   wb_valid_d;
    logic              wb_we_q,      wb_we_d;
    logic [4:0]        wb_rd_q,      wb_rd_d;
    logic [31:0]       wb_data_q,    wb_data_d;
    logic [1:0]        err_q,        err_d;
    logic [7:0]        cnt_q,        cnt_d;
    // Destination of an in-flight LW, applied when the memory answers.
    logic [4:0]        pend_rd_q,    pend_rd_d;
    logic              pend_we_q,    pend_we_d;

    logic       accept;
    logic [5:0] opcode;
    logic       dec_writes;
    logic [4:0] dec_dest;
    logic       is_lw;
    logic       is_sw;
    logic       misaligned;
    logic       unused_instr_bits;

    assign unused_instr_bits = ^instr_i[10:0];

    // in_ready_o is gated by rst directly so it is low for the whole reset pulse.
    assign in_ready_o = !rst && (state_q != ST_MEM);
    assign accept     = in_valid_i && in_ready_o;

    assign opcode     = instr_i[31:26];
    assign is_lw      = (opcode == OPCODE_LW);
    assign is_sw      = (opcode == OPCODE_SW);
    assign misaligned = (alu_result_i[1:0] != 2'b00);

    always_comb begin
        dec_writes = 1'b0;
        dec_dest   = 5'd0;
        case (opcode)
            OPCODE_RTYPE_SPECIAL1, OPCODE_RTYPE_SPECIAL2, OPCODE_MUL: begin
                dec_writes = 1'b1;
                dec_dest   = instr_i[15:11];
            end
            OPCODE_ADDI, OPCODE_ANDI, OPCODE_ORI, OPCODE_SLTI, OPCODE_LW: begin
                dec_writes = 1'b1;
                dec_dest   = instr_i[20:16];
            end
            default: begin
                dec_writes = 1'b0;
                dec_dest   = 5'd0;
            end
        endcase
    end

    always_comb begin
        state_d      = state_q;
        dmem_req_d   = dmem_req_q;
        dmem_we_d    = dmem_we_q;
        dmem_addr_d  = dmem_addr_q;
        dmem_wdata_d = dmem_wdata_q;
        wb_valid_d   = 1'b0;
        wb_we_d      = wb_we_q;
        wb_rd_d      = wb_rd_q;
        wb_data_d    = wb_data_q;
        err_d        = err_q;
        cnt_d        = cnt_q;
        pend_rd_d    = pend_rd_q;
        pend_we_d    = pend_we_q;

        if (state_q == ST_MEM) begin
            if (dmem_ack_i) begin
                // An ack on the last permitted cycle still counts as success.
                dmem_req_d = 1'b0;
                wb_valid_d = 1'b1;
                wb_rd_d    = pend_rd_q;
                err_d      = ERR_OK;
                if (dmem_we_q) begin
                    wb_we_d   = 1'b0;
                    wb_data_d = 32'(dmem_addr_q);
                end else begin
                    wb_we_d   = pend_we_q;
                    wb_data_d = dmem_rdata_i;
                end
                state_d = ST_DONE;
            end else if (cnt_q == CNT_LAST) begin
                dmem_req_d = 1'b0;
                wb_valid_d = 1'b1;
                wb_we_d    = 1'b0;
                wb_rd_d    = pend_rd_q;
                err_d      = ERR_TIMEOUT;
                state_d    = ST_DONE;
            end else begin
                cnt_d = cnt_q + 8'd1;
            end
        end else if (accept) begin
            if ((is_lw || is_sw) && !misaligned) begin
                dmem_req_d   = 1'b1;
                dmem_we_d    = is_sw;
                dmem_addr_d  = alu_result_i[ADDR_W-1:0];
                dmem_wdata_d = store_data_i;
                pend_rd_d    = dec_dest;
                pend_we_d    = dec_writes && (dec_dest != 5'd0);
                cnt_d        = 8'd0;
                state_d      = ST_MEM;
            end else begin
                wb_valid_d = 1'b1;
                wb_rd_d    = dec_dest;
                wb_data_d  = alu_result_i;
                if (is_lw || is_sw) begin
                    wb_we_d = 1'b0;
                    err_d   = ERR_MISALIGN;
                end else begin
                    wb_we_d = dec_writes && (dec_dest != 5'd0);
                    err_d   = ERR_OK;
                end
                state_d = ST_DONE;
            end
        end else begin
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            dmem_req_q   <= 1'b0;
            dmem_we_q    <= 1'b0;
            dmem_addr_q  <= '0;
            dmem_wdata_q <= 32'd0;
            wb_valid_q   <= 1'b0;
            wb_we_q      <= 1'b0;
            wb_rd_q      <= 5'd0;
            wb_data_q    <= 32'd0;
            err_q        <= 2'b00;
            cnt_q        <= 8'd0;
            pend_rd_q    <= 5'd0;
            pend_we_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            dmem_req_q   <= dmem_req_d;
            dmem_we_q    <= dmem_we_d;
            dmem_addr_q  <= dmem_addr_d;
            dmem_wdata_q <= dmem_wdata_d;
            wb_valid_q   <= wb_valid_d;
            wb_we_q      <= wb_we_d;
            wb_rd_q      <= wb_rd_d;
            wb_data_q    <= wb_data_d;
            err_q        <= err_d;
            cnt_q        <= cnt_d;
            pend_rd_q    <= pend_rd_d;
            pend_we_q    <= pend_we_d;
        end
    end

    assign dmem_req_o   = dmem_req_q;
    assign dmem_we_o    = dmem_we_q;
    assign dmem_addr_o  = dmem_addr_q;
    assign dmem_wdata_o = dmem_wdata_q;
    assign wb_valid_o   = wb_valid_q;
    assign wb_we_o      = wb_we_q;
    assign wb_rd_o      = wb_rd_q;
    assign wb_data_o    = wb_data_q;
    assign err_o        = err_q;

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - directed self-checking bench for mem_stage
module tb_mem_stage;
    import definitions_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [31:0] instr_i;
    logic [31:0] alu_result_i;
    logic [31:0] store_data_i;
    logic        dmem_req_o;
    logic        dmem_we_o;
    logic [31:0] dmem_addr_o;
    logic [31:0] dmem_wdata_o;
    logic        dmem_ack_i;
    logic [31:0] dmem_rdata_i;
    logic        wb_valid_o;
    logic        wb_we_o;
    logic [4:0]  wb_rd_o;
    logic [31:0] wb_data_o;
    logic [1:0]  err_o;

    int n_tests = 0;
    int n_fail  = 0;
    int req_cycles;

    mem_stage #(.ADDR_W(32), .TIMEOUT_CYCLES(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid_i   (in_valid_i),
        .in_ready_o   (in_ready_o),
        .instr_i      (instr_i),
        .alu_result_i (alu_result_i),
        .store_data_i (store_data_i),
        .dmem_req_o   (dmem_req_o),
        .dmem_we_o    (dmem_we_o),
        .dmem_addr_o  (dmem_addr_o),
        .dmem_wdata_o (dmem_wdata_o),
        .dmem_ack_i   (dmem_ack_i),
        .dmem_rdata_i (dmem_rdata_i),
        .wb_valid_o   (wb_valid_o),
        .wb_we_o      (wb_we_o),
        .wb_rd_o      (wb_rd_o),
        .wb_data_o    (wb_data_o),
        .err_o        (err_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one instruction for a single accepting edge.
    task automatic issue(input logic [31:0] instr, input logic [31:0] alu, input logic [31:0] sd);
        in_valid_i   = 1'b1;
        instr_i      = instr;
        alu_result_i = alu;
        store_data_i = sd;
        tick();
        in_valid_i   = 1'b0;
    endtask

    // Count request cycles, checking the request stays stable; ack during request cycle ack_at
    // (0 = never). Returns with the first sample after the request dropped.
    task automatic run_mem(input int ack_at, input logic [31:0] rdata, input logic exp_we,
                           input logic [31:0] exp_addr, input logic [31:0] exp_wdata,
                           output int cycles);
        cycles = 0;
        while (dmem_req_o && cycles < 40) begin
            cycles++;
            check("req_we_stable", 32'(dmem_we_o), 32'(exp_we));
            check("req_addr_stable", dmem_addr_o, exp_addr);
            if (exp_we) check("req_wdata_stable", dmem_wdata_o, exp_wdata);
            check("in_ready_in_mem", 32'(in_ready_o), 32'd0);
            if (cycles == ack_at) begin
                dmem_ack_i   = 1'b1;
                dmem_rdata_i = rdata;
            end
            tick();
            dmem_ack_i   = 1'b0;
            dmem_rdata_i = 32'h0;
        end
    endtask

    initial begin
        rst          = 1'b1;
        in_valid_i   = 1'b0;
        instr_i      = 32'h0;
        alu_result_i = 32'h0;
        store_data_i = 32'h0;
        dmem_ack_i   = 1'b0;
        dmem_rdata_i = 32'h0;

        // Reset state
        #12;
        check("rst_in_ready", 32'(in_ready_o), 32'd0);
        check("rst_req", 32'(dmem_req_o), 32'd0);
        check("rst_wb_valid", 32'(wb_valid_o), 32'd0);
        check("rst_wb_data", wb_data_o, 32'h0);
        check("rst_err", 32'(err_o), 32'd0);
        check("rst_addr", dmem_addr_o, 32'h0);
        @(posedge clk);
        #1 rst = 1'b0;
        #1;
        check("idle_in_ready", 32'(in_ready_o), 32'd1);

        // ADD rd=5
        issue({OPCODE_RTYPE_SPECIAL1, 5'd1, 5'd2, 5'd5, 5'd0, FUNCT_ADD}, 32'h0000_1234, 32'h0);
        check("add_wb_valid", 32'(wb_valid_o), 32'd1);
        check("add_wb_we", 32'(wb_we_o), 32'd1);
        check("add_wb_rd", 32'(wb_rd_o), 32'd5);
        check("add_wb_data", wb_data_o, 32'h0000_1234);
        check("add_err", 32'(err_o), 32'd0);
        check("add_no_req", 32'(dmem_req_o), 32'd0);
        tick();
        check("add_pulse_end", 32'(wb_valid_o), 32'd0);
        check("add_data_hold", wb_data_o, 32'h0000_1234);

        // Spurious ack while idle is ignored
        dmem_ack_i = 1'b1;
        tick();
        dmem_ack_i = 1'b0;
        check("spurious_ack_wb", 32'(wb_valid_o), 32'd0);
        check("spurious_ack_req", 32'(dmem_req_o), 32'd0);

        // LW rt=8, ack in third request cycle
        issue({OPCODE_LW, 5'd1, 5'd8, 16'h0100}, 32'h0000_0100, 32'h0);
        run_mem(3, 32'hDEAD_BEEF, 1'b0, 32'h100, 32'h0, req_cycles);
        check("lw_req_cycles", 32'(req_cycles), 32'd3);
        check("lw_wb_valid", 32'(wb_valid_o), 32'd1);
        check("lw_wb_data", wb_data_o, 32'hDEAD_BEEF);
        check("lw_wb_rd", 32'(wb_rd_o), 32'd8);
        check("lw_wb_we", 32'(wb_we_o), 32'd1);
        check("lw_err", 32'(err_o), 32'd0);
        tick();

        // SW, ack in first request cycle
        issue({OPCODE_SW, 5'd1, 5'd9, 16'h0104}, 32'h0000_0104, 32'hCAFE_F00D);
        run_mem(1, 32'h0, 1'b1, 32'h104, 32'hCAFE_F00D, req_cycles);
        check("sw_req_cycles", 32'(req_cycles), 32'd1);
        check("sw_wb_valid", 32'(wb_valid_o), 32'd1);
        check("sw_wb_we", 32'(wb_we_o), 32'd0);
        check("sw_wb_data", wb_data_o, 32'h0000_0104);
        check("sw_err", 32'(err_o), 32'd0);
        tick();

        // Misaligned LW
        issue({OPCODE_LW, 5'd1, 5'd8, 16'h0102}, 32'h0000_0102, 32'h0);
        check("mis_no_req", 32'(dmem_req_o), 32'd0);
        check("mis_wb_valid", 32'(wb_valid_o), 32'd1);
        check("mis_wb_we", 32'(wb_we_o), 32'd0);
        check("mis_err", 32'(err_o), 32'd1);
        tick();

        // LW timeout, never acked
        issue({OPCODE_LW, 5'd1, 5'd7, 16'h0200}, 32'h0000_0200, 32'h0);
        run_mem(0, 32'h0, 1'b0, 32'h200, 32'h0, req_cycles);
        check("to_req_cycles", 32'(req_cycles), 32'd16);
        check("to_wb_valid", 32'(wb_valid_o), 32'd1);
        check("to_wb_we", 32'(wb_we_o), 32'd0);
        check("to_err", 32'(err_o), 32'd2);
        tick();

        // LW acked on the 16th (final) cycle: ack wins
        issue({OPCODE_LW, 5'd1, 5'd7, 16'h0204}, 32'h0000_0204, 32'h0);
        run_mem(16, 32'h1357_9BDF, 1'b0, 32'h204, 32'h0, req_cycles);
        check("last_req_cycles", 32'(req_cycles), 32'd16);
        check("last_wb_valid", 32'(wb_valid_o), 32'd1);
        check("last_err", 32'(err_o), 32'd0);
        check("last_wb_data", wb_data_o, 32'h1357_9BDF);
        check("last_wb_we", 32'(wb_we_o), 32'd1);
        check("last_wb_rd", 32'(wb_rd_o), 32'd7);
        tick();
        check("err_hold_idle", 32'(err_o), 32'd0);

        // Back-to-back ADDI rt=0 then ORI rt=3
        in_valid_i   = 1'b1;
        instr_i      = {OPCODE_ADDI, 5'd1, 5'd0, 16'h0011};
        alu_result_i = 32'h0000_0011;
        tick();
        check("b2b1_wb_valid", 32'(wb_valid_o), 32'd1);
        check("b2b1_wb_we", 32'(wb_we_o), 32'd0);
        check("b2b1_in_ready", 32'(in_ready_o), 32'd1);
        instr_i      = {OPCODE_ORI, 5'd1, 5'd3, 16'h0055};
        alu_result_i = 32'h0000_0055;
        tick();
        in_valid_i   = 1'b0;
        check("b2b2_wb_valid", 32'(wb_valid_o), 32'd1);
        check("b2b2_wb_we", 32'(wb_we_o), 32'd1);
        check("b2b2_wb_rd", 32'(wb_rd_o), 32'd3);
        check("b2b2_wb_data", wb_data_o, 32'h0000_0055);
        tick();
        check("b2b_end", 32'(wb_valid_o), 32'd0);

        // Reset asserted during MEM
        issue({OPCODE_LW, 5'd1, 5'd4, 16'h0300}, 32'h0000_0300, 32'h0);
        check("rstmem_req_up", 32'(dmem_req_o), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("rstmem_req_drop", 32'(dmem_req_o), 32'd0);
        check("rstmem_in_ready", 32'(in_ready_o), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        #1;
        check("rstmem_ready_after", 32'(in_ready_o), 32'd1);
        check("rstmem_no_wb", 32'(wb_valid_o), 32'd0);
        dmem_ack_i = 1'b1;
        tick();
        dmem_ack_i = 1'b0;
        check("rstmem_no_wb_late", 32'(wb_valid_o), 32'd0);
        check("rstmem_req_low", 32'(dmem_req_o), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access/writeback-prep stage directly downstream of the execute ALU in the MIPS pipeline.
- Accepts one executed instruction: ALU result, instruction word and store data.
- LW/SW: runs a req/ack transaction to data memory. All instructions: produces a registered writeback record (dest reg, data, write enable) for the register file.
- Detects misaligned word accesses and memory timeouts.

Parameters:
- ADDR_W, 32, width of dmem_addr_o. The low ADDR_W bits of the ALU result form a byte address.
- TIMEOUT_CYCLES, 16, maximum cycles dmem_req_o is held without dmem_ack_i before abort. Legal range 1..255.

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous active-high reset
- in_valid_i  input  1  executed instruction present
- in_ready_o  output  1  stage can accept this cycle
- instr_i  input  32  instruction word
- alu_result_i  input  32  ALU result (effective address for LW/SW)
- store_data_i  input  32  rt value for SW
- dmem_req_o  output  1  memory request, held until ack
- dmem_we_o  output  1  1 = write (SW), 0 = read (LW)
- dmem_addr_o  output  ADDR_W  byte address
- dmem_wdata_o  output  32  store data
- dmem_ack_i  input  1  memory completes request this cycle
- dmem_rdata_i  input  32  load data, valid with ack
- wb_valid_o  output  1  one-cycle pulse per retired instruction
- wb_we_o  output  1  register-file write enable
- wb_rd_o  output  5  destination register
- wb_data_o  output  32  writeback data
- err_o  output  2  with wb_valid_o: 00 ok, 01 misaligned, 10 timeout

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous and active-high. While rst is high, every register clears immediately: state=IDLE, dmem_req_o=0, dmem_we_o=0, dmem_addr_o=0, dmem_wdata_o=0, wb_valid_o=0, wb_we_o=0, wb_rd_o=0, wb_data_o=0, err_o=00, timeout counter=0. in_ready_o=0 while rst is high.
- FSM states:
  - IDLE: in_ready_o=1.
  - MEM: in_ready_o=0.
  - DONE: in_ready_o=1; holds the writeback pulse for one cycle.
- Accept: a transfer happens when in_valid_i && in_ready_o at a clock edge. instr_i, alu_result_i and store_data_i are captured.
- Decode uses the definitions_pkg opcode constants:
  - OPCODE_RTYPE_SPECIAL1, OPCODE_RTYPE_SPECIAL2, OPCODE_MUL: dest = instr[15:11], write.
  - OPCODE_ADDI, OPCODE_ANDI, OPCODE_ORI, OPCODE_SLTI, OPCODE_LW: dest = instr[20:16], write.
  - OPCODE_SW, OPCODE_BEQ, OPCODE_BNE, OPCODE_J and any other opcode: no write, wb_we_o=0.
  - A dest of register 0 forces wb_we_o=0.
- Non-memory instruction accepted at edge N: at N+1, wb_valid_o=1, wb_data_o=alu_result, err_o=00; state=DONE.
- LW/SW with alu_result[1:0]!=0: no memory request. At N+1, wb_valid_o=1, wb_we_o=0, err_o=01.
- Aligned LW/SW accepted at edge N:
  - From N+1: dmem_req_o=1, with dmem_addr_o, dmem_we_o (SW=1) and dmem_wdata_o registered and stable until the request ends. State=MEM.
  - Request completes at the first edge M where dmem_req_o && dmem_ack_i. dmem_req_o drops at M+1.
  - At M+1: wb_valid_o=1. LW: wb_data_o=dmem_rdata_i sampled at M. SW: wb_we_o=0, wb_data_o=address.
- Timeout:
  - The counter clears on entering MEM and increments each MEM cycle without ack.
  - If no ack by the edge where the counter equals TIMEOUT_CYCLES-1, the request is aborted. dmem_req_o was high exactly TIMEOUT_CYCLES cycles.
  - Abort response: wb_valid_o=1, wb_we_o=0, err_o=10.
  - An ack on that final edge wins: normal completion, err_o=00.
- DONE: wb_valid_o is high this cycle only. A new accept in DONE proceeds exactly as from IDLE, giving a back-to-back throughput of 1/cycle for non-memory ops. Without an accept, the next state is IDLE and wb_valid_o=0.
- wb_rd_o, wb_data_o and err_o hold their last values when wb_valid_o=0. err_o is 00 on every successful retire.
- dmem_ack_i outside MEM (spurious or late) is ignored.
- Reset asserted mid-MEM: dmem_req_o drops asynchronously; no writeback is produced for the aborted instruction.
- Address: dmem_addr_o = alu_result[ADDR_W-1:0], with no translation.

Test Plan:
- ADD (funct FUNCT_ADD, rd=5) with alu_result=0x00001234 -> one cycle later: wb_valid=1, wb_we=1, wb_rd=5, wb_data=0x00001234, err=00. No dmem_req.
- LW rt=8, alu_result=0x100, ack 3 cycles after req rises with rdata=0xDEADBEEF -> dmem_req high exactly 3 cycles with addr=0x100, we=0. Next cycle: wb_data=0xDEADBEEF, wb_rd=8, wb_we=1.
- SW, alu_result=0x104, store_data=0xCAFEF00D, ack after 1 cycle -> dmem_we=1, wdata=0xCAFEF00D. Writeback pulse with wb_we=0, err=00.
- LW with alu_result=0x102 -> no dmem_req. Next cycle: wb_valid=1, wb_we=0, err=01.
- LW, TIMEOUT_CYCLES=16, ack never -> dmem_req high exactly 16 cycles, then wb_valid=1, err=10. Repeat with ack on the 16th cycle -> err=00 and data captured.
- Back-to-back ADDI rt=0 then ORI rt=3 -> pulses on consecutive cycles with wb_we=0 then 1. Separately, rst pulsed while in MEM -> dmem_req low immediately, no wb_valid, in_ready=1 after release.
